// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: mul/div ops, forwarding selects,
// destination selects and ALU function codes.
package ex_pkg;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_K0 = 2'b11;

  localparam logic [5:0] ALU_SLL = 6'h00;
  localparam logic [5:0] ALU_SRL = 6'h02;
  localparam logic [5:0] ALU_SRA = 6'h03;
  localparam logic [5:0] ALU_LUI = 6'h0F;
  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;
  localparam logic [5:0] ALU_XOR = 6'h26;
  localparam logic [5:0] ALU_NOR = 6'h27;
  localparam logic [5:0] ALU_SLT = 6'h2A;
endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts move operand b by the low bits of operand a;
// sign selects signed or unsigned set-less-than.
module alu
  import ex_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [5:0]        ctl,
  input  logic              sign,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  logic            lt;

  always_comb begin
    sh = a[SH_W-1:0];
    lt = sign ? ($signed(a) < $signed(b)) : (a < b);
    case (ctl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, lt};
      ALU_SLL: y = b << sh;
      ALU_SRL: y = b >> sh;
      ALU_SRA: y = $signed(b) >>> sh;
      ALU_LUI: y = b << (DATA_W / 2);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/md_iter.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle,
// DATA_W steps, on magnitudes with sign fix-up when HI/LO are written.
module md_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic busy_q, busy_d, is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] p_q, p_d, p_step, prod;
  logic [DATA_W:0]     sum, shifted, diff;
  logic [DATA_W-1:0]   q_res, r_res;
  logic                signed_op, sa, sb;

  always_comb begin
    busy_d = busy_q; cnt_d = cnt_q; is_div_d = is_div_q; neg_d = neg_q;
    rneg_d = rneg_q; dz_d = dz_q; a_d = a_q; b_d = b_q; p_d = p_q;
    hi_d = hi_q; lo_d = lo_q;
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    sa = signed_op && a[DATA_W-1];
    sb = signed_op && b[DATA_W-1];
    // p holds {partial product, multiplier} or {remainder, dividend/quotient}
    sum     = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, b_q} : '0);
    shifted = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    diff    = shifted - {1'b0, b_q};
    if (is_div_q)
      p_step = diff[DATA_W] ? {shifted[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
    else
      p_step = {sum, p_q[DATA_W-1:1]};
    prod  = neg_q ? -p_step : p_step;
    q_res = neg_q ? -p_step[DATA_W-1:0] : p_step[DATA_W-1:0];
    r_res = rneg_q ? -p_step[2*DATA_W-1:DATA_W] : p_step[2*DATA_W-1:DATA_W];

    if (busy_q) begin
      p_d   = p_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (is_div_q) begin
          lo_d = dz_q ? '1 : q_res;
          hi_d = dz_q ? a_q : r_res;
        end else begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
      end
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      is_div_d = (op == MD_DIV) || (op == MD_DIVU);
      neg_d    = sa ^ sb;
      rneg_d   = sa;
      dz_d     = (b == '0);
      a_d      = a;
      b_d      = sb ? -b : b;
      p_d      = {{DATA_W{1'b0}}, (sa ? -a : a)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0; cnt_q <= '0; is_div_q <= 1'b0; neg_q <= 1'b0;
      rneg_q <= 1'b0; dz_q <= 1'b0; a_q <= '0; b_q <= '0; p_q <= '0;
      hi_q <= '0; lo_q <= '0;
    end else begin
      busy_q <= busy_d; cnt_q <= cnt_d; is_div_q <= is_div_d; neg_q <= neg_d;
      rneg_q <= rneg_d; dz_q <= dz_d; a_q <= a_d; b_q <= b_d; p_q <= p_d;
      hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: rtl/ex_md_stage.sv
// Execute stage: operand forwarding, ALU, destination select, iterative
// mul/div with HI/LO and ID stall, feeding the EX/MEM register.
module ex_md_stage
  import ex_pkg::*;
#(
  parameter int              DATA_W = DEF_DATA_W,
  parameter int              RA_W   = 5,
  parameter logic [RA_W-1:0] RA_REG = RA_W'(31),
  parameter logic [RA_W-1:0] K0_REG = RA_W'(26)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [5:0]        alu_ctl,
  input  logic              alu_sign,
  input  logic              alu_src1,
  input  logic              alu_src2,
  input  logic [1:0]        reg_dst,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] shamt,
  input  logic [DATA_W-1:0] imm,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [1:0]        mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_wr_reg,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_wr_reg,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic [RA_W-1:0]   ex_wr_reg,
  output logic              md_busy,
  output logic              exm_valid,
  output logic [DATA_W-1:0] exm_wdata,
  output logic [DATA_W-1:0] exm_result,
  output logic [RA_W-1:0]   exm_wr_reg,
  output logic              exm_mem_write,
  output logic [1:0]        exm_mem_to_reg,
  output logic              exm_reg_write
);
  fwd_e              fwd_a, fwd_b;
  logic [DATA_W-1:0] rs_val, rt_val, op1, op2, alu_y, hi, lo;
  logic              md_arith, stall, md_start, live;

  logic              exm_valid_q, exm_valid_d, exm_mem_write_q, exm_mem_write_d;
  logic              exm_reg_write_q, exm_reg_write_d;
  logic [1:0]        exm_mem_to_reg_q, exm_mem_to_reg_d;
  logic [DATA_W-1:0] exm_wdata_q, exm_wdata_d, exm_result_q, exm_result_d;
  logic [RA_W-1:0]   exm_wr_reg_q, exm_wr_reg_d;

  // Writes to r0 are ignored by the regfile, so they must never be forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    if (mem_reg_write && mem_wr_reg != '0 && mem_wr_reg == rs)   fwd_a = FWD_MEM;
    else if (wb_reg_write && wb_wr_reg != '0 && wb_wr_reg == rs) fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (mem_reg_write && mem_wr_reg != '0 && mem_wr_reg == rt)   fwd_b = FWD_MEM;
    else if (wb_reg_write && wb_wr_reg != '0 && wb_wr_reg == rt) fwd_b = FWD_WB;
    case (fwd_a)
      FWD_MEM: rs_val = mem_wr_data;
      FWD_WB:  rs_val = wb_wr_data;
      default: rs_val = rs_data;
    endcase
    case (fwd_b)
      FWD_MEM: rt_val = mem_wr_data;
      FWD_WB:  rt_val = wb_wr_data;
      default: rt_val = rt_data;
    endcase
    op1 = alu_src1 ? shamt : rs_val;
    op2 = alu_src2 ? imm : rt_val;
  end

  always_comb begin
    case (reg_dst)
      REGDST_RT: ex_wr_reg = rt;
      REGDST_RD: ex_wr_reg = rd;
      REGDST_RA: ex_wr_reg = RA_REG;
      REGDST_K0: ex_wr_reg = K0_REG;
    endcase
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .ctl (alu_ctl),
    .sign(alu_sign),
    .a   (op1),
    .b   (op2),
    .y   (alu_y)
  );

  md_iter #(.DATA_W(DATA_W)) u_md_iter (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (md_op),
    .a    (rs_val),
    .b    (rt_val),
    .busy (md_busy),
    .hi   (hi),
    .lo   (lo)
  );

  assign md_arith = (md_op >= MD_MULT) && (md_op <= MD_DIVU);
  assign stall    = in_valid && md_busy && (md_op != MD_NONE);
  assign in_ready = !stall;
  assign md_start = in_valid && !flush && !md_busy && md_arith;
  // mul/div issue leaves EX as a bubble; its result arrives later via mfhi/mflo
  assign live     = in_valid && !flush && !stall && !md_arith;

  always_comb begin
    exm_valid_d      = live;
    exm_reg_write_d  = live && reg_write;
    exm_mem_write_d  = live && mem_write;
    exm_mem_to_reg_d = live ? mem_to_reg : 2'b00;
    exm_wdata_d      = rt_val;
    exm_wr_reg_d     = ex_wr_reg;
    if (md_op == MD_MFHI)      exm_result_d = hi;
    else if (md_op == MD_MFLO) exm_result_d = lo;
    else                       exm_result_d = alu_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_valid_q <= 1'b0; exm_reg_write_q <= 1'b0; exm_mem_write_q <= 1'b0;
      exm_mem_to_reg_q <= '0; exm_wdata_q <= '0; exm_result_q <= '0; exm_wr_reg_q <= '0;
    end else begin
      exm_valid_q <= exm_valid_d; exm_reg_write_q <= exm_reg_write_d;
      exm_mem_write_q <= exm_mem_write_d; exm_mem_to_reg_q <= exm_mem_to_reg_d;
      exm_wdata_q <= exm_wdata_d; exm_result_q <= exm_result_d; exm_wr_reg_q <= exm_wr_reg_d;
    end
  end

  assign exm_valid      = exm_valid_q;
  assign exm_reg_write  = exm_reg_write_q;
  assign exm_mem_write  = exm_mem_write_q;
  assign exm_mem_to_reg = exm_mem_to_reg_q;
  assign exm_wdata      = exm_wdata_q;
  assign exm_result     = exm_result_q;
  assign exm_wr_reg     = exm_wr_reg_q;
endmodule

// File: tb/tb_ex_md_stage.sv
// Randomized and directed bench for ex_md_stage against an arithmetic reference
// model of forwarding, the ALU and mul/div HI/LO results.
module tb_ex_md_stage;
  import ex_pkg::*;

  logic        clk, rst, in_valid, in_ready, flush, alu_sign, alu_src1, alu_src2;
  logic [5:0]  alu_ctl;
  logic [1:0]  reg_dst, mem_to_reg, exm_mem_to_reg;
  logic [2:0]  md_op;
  logic [31:0] shamt, imm, rs_data, rt_data, mem_wr_data, wb_wr_data, exm_wdata, exm_result;
  logic [4:0]  rs, rt, rd, mem_wr_reg, wb_wr_reg, ex_wr_reg, exm_wr_reg;
  logic        mem_write, reg_write, mem_reg_write, wb_reg_write, md_busy;
  logic        exm_valid, exm_mem_write, exm_reg_write;

  int          errors = 0;
  int          checks = 0;

  ex_md_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_ctl(alu_ctl), .alu_sign(alu_sign), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .reg_dst(reg_dst), .md_op(md_op), .shamt(shamt), .imm(imm), .rs(rs), .rt(rt), .rd(rd),
    .rs_data(rs_data), .rt_data(rt_data), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_reg_write(mem_reg_write), .mem_wr_reg(mem_wr_reg),
    .mem_wr_data(mem_wr_data), .wb_reg_write(wb_reg_write), .wb_wr_reg(wb_wr_reg),
    .wb_wr_data(wb_wr_data), .ex_wr_reg(ex_wr_reg), .md_busy(md_busy),
    .exm_valid(exm_valid), .exm_wdata(exm_wdata), .exm_result(exm_result),
    .exm_wr_reg(exm_wr_reg), .exm_mem_write(exm_mem_write),
    .exm_mem_to_reg(exm_mem_to_reg), .exm_reg_write(exm_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else
      $display("ok   %s = %0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 0; flush = 0; alu_ctl = ALU_ADD; alu_sign = 0; alu_src1 = 0; alu_src2 = 0;
    reg_dst = REGDST_RD; md_op = MD_NONE; shamt = 0; imm = 0; rs = 1; rt = 2; rd = 3;
    rs_data = 0; rt_data = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    mem_reg_write = 0; mem_wr_reg = 0; mem_wr_data = 0;
    wb_reg_write = 0; wb_wr_reg = 0; wb_wr_data = 0;
  endtask

  task automatic set_alu(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    in_valid = 1; reg_write = 1; alu_ctl = ctl; rs_data = a; rt_data = b;
  endtask

  task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    in_valid = 1; reg_write = 1; md_op = op; rs_data = a; rt_data = b;
  endtask

  task automatic wait_ready(output int stalls);
    stalls = 0;
    while (stalls < 200) begin
      #1;
      if (in_ready) break;
      stalls++;
      tick();
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l, output int stalls);
    set_md(MD_MFHI, 0, 0);
    wait_ready(stalls);
    tick();
    h = exm_result;
    chk("mfhi_regwr", {63'b0, exm_reg_write}, 64'd1);
    set_md(MD_MFLO, 0, 0);
    tick();
    l = exm_result;
    clear_in();
  endtask

  // Issue a mul/div, optionally idle a few cycles, then read HI/LO back.
  task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int idle, output logic [31:0] h, output logic [31:0] l);
    int stalls;
    set_md(op, a, b);
    tick();
    chk("md_issue_bubble", {61'b0, exm_valid, exm_reg_write, exm_mem_write}, 64'd0);
    chk("md_busy_set", {63'b0, md_busy}, 64'd1);
    clear_in();
    for (int i = 0; i < idle; i++) tick();
    read_hilo(h, l, stalls);
    chk("md_stall_cycles", 64'(stalls), 64'(32 - idle));
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (mem_reg_write && mem_wr_reg == r) return mem_wr_data;
    if (wb_reg_write && wb_wr_reg == r) return wb_wr_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic s,
                                          input logic [31:0] x, input logic [31:0] y);
    int unsigned n;
    n = x % 32;
    case (c)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      ALU_NOR: return ~(x | y);
      ALU_SLT: return s ? ((int'(x) < int'(y)) ? 32'd1 : 32'd0) : ((x < y) ? 32'd1 : 32'd0);
      ALU_SLL: return y << n;
      ALU_SRL: return y >> n;
      ALU_SRA: return 32'(int'(y) >>> n);
      ALU_LUI: return y * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'h0, a};           ub = {32'h0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV:   return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
      default:  return 64'd0;
    endcase
  endfunction

  logic [5:0]  ops [11] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                            ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
  logic [31:0] exp_a, exp_b, exp_res, gh, gl;
  logic [63:0] exp_md;
  logic [4:0]  exp_dst;
  logic        ok;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  int          stalls;

  initial begin
    clear_in();
    rst = 1;
    tick(); tick();
    chk("rst_exm", {exm_valid, exm_reg_write, exm_mem_write, exm_mem_to_reg, exm_wr_reg,
                    exm_result[15:0], exm_wdata[15:0]}, 64'd0);
    chk("rst_busy", {63'b0, md_busy}, 64'd0);
    rst = 0;
    tick();
    read_hilo(gh, gl, stalls);
    chk("rst_hi", gh, 0);
    chk("rst_lo", gl, 0);

    // Forwarding priority and r0 exclusion
    set_alu(ALU_ADD, 32'h1, 32'd100);
    rs = 5; rt = 6;
    mem_reg_write = 1; mem_wr_reg = 5; mem_wr_data = 32'h11;
    wb_reg_write = 1;  wb_wr_reg = 5;  wb_wr_data = 32'h22;
    tick();
    chk("fwd_mem_over_wb", exm_result, 32'h11 + 32'd100);
    set_alu(ALU_ADD, 32'h0, 32'd100);
    rs = 0; rt = 6; mem_write = 1;
    mem_reg_write = 1; mem_wr_reg = 0; mem_wr_data = 32'h11;
    wb_reg_write = 1;  wb_wr_reg = 6;  wb_wr_data = 32'h33;
    tick();
    chk("fwd_r0_regfile", exm_result, 32'h33);
    chk("fwd_store_data", exm_wdata, 32'h33);
    chk("store_memwr", {63'b0, exm_mem_write}, 64'd1);

    // Randomized ALU / forwarding / destination traffic
    for (int i = 0; i < 30; i++) begin
      clear_in();
      in_valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 7) == 0);
      alu_ctl = ops[$urandom_range(0, 10)];
      alu_sign = 1'($urandom_range(0, 1));
      alu_src1 = ($urandom_range(0, 3) == 0);
      alu_src2 = ($urandom_range(0, 3) == 0);
      reg_dst = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
      rs_data = $urandom; rt_data = $urandom; shamt = $urandom_range(0, 31); imm = $urandom;
      mem_reg_write = 1'($urandom_range(0, 1)); mem_wr_reg = 5'($urandom_range(0, 7));
      mem_wr_data = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_wr_reg = 5'($urandom_range(0, 7));
      wb_wr_data = $urandom;
      reg_write = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
      mem_to_reg = 2'($urandom_range(0, 3));
      exp_a = fwd_ref(rs, rs_data);
      exp_b = fwd_ref(rt, rt_data);
      exp_res = ref_alu(alu_ctl, alu_sign, alu_src1 ? shamt : exp_a, alu_src2 ? imm : exp_b);
      exp_dst = (reg_dst == 0) ? rt : (reg_dst == 1) ? rd : (reg_dst == 2) ? 5'd31 : 5'd26;
      ok = in_valid && !flush;
      #1;
      chk("ex_wr_reg", ex_wr_reg, exp_dst);
      tick();
      chk("alu_valid", {63'b0, exm_valid}, {63'b0, ok});
      chk("alu_regwr", {63'b0, exm_reg_write}, {63'b0, ok && reg_write});
      chk("alu_memwr", {63'b0, exm_mem_write}, {63'b0, ok && mem_write});
      if (ok) begin
        chk("alu_result", exm_result, exp_res);
        chk("alu_wdata", exm_wdata, exp_b);
        chk("alu_wr_reg", exm_wr_reg, exp_dst);
      end
    end

    // mult -3 * 5, then the HI/LO reads stall for the full iteration count
    md_run(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, gh, gl);
    chk("mult_lo", gl, 32'hFFFFFFF1);
    chk("mult_hi", gh, 32'hFFFFFFFF);

    // div -7 / 2 with idle cycles in between; divide by zero
    md_run(MD_DIV, 32'hFFFFFFF9, 32'd2, 5, gh, gl);
    chk("div_lo", gl, 32'hFFFFFFFD);
    chk("div_hi", gh, 32'hFFFFFFFF);
    md_run(MD_DIVU, 32'd9, 32'd0, 0, gh, gl);
    chk("divu0_lo", gl, 32'hFFFFFFFF);
    chk("divu0_hi", gh, 32'd9);
    md_run(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, gh, gl);
    chk("intmin_lo", gl, 32'h80000000);
    chk("intmin_hi", gh, 32'd0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      exp_md = md_ref(rop, ra, rb);
      md_run(rop, ra, rb, 0, gh, gl);
      chk("rand_md_hi", gh, exp_md[63:32]);
      chk("rand_md_lo", gl, exp_md[31:0]);
    end

    // divu running while three independent adds flow through
    set_md(MD_DIVU, 32'd100, 32'd7);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_alu(ALU_ADD, 32'(k * 10), 32'd1);
      #1;
      chk("add_ready", {63'b0, in_ready}, 64'd1);
      tick();
      chk("add_valid", {63'b0, exm_valid}, 64'd1);
      chk("add_result", exm_result, 64'(k * 10 + 1));
      chk("add_busy", {63'b0, md_busy}, 64'd1);
    end
    read_hilo(gh, gl, stalls);
    chk("divu_adds_stalls", 64'(stalls), 64'd29);
    chk("divu_hi", gh, 32'd2);
    chk("divu_lo", gl, 32'd14);

    // Asynchronous reset in the middle of a mult
    set_md(MD_MULT, 32'd123, 32'd456);
    tick();
    for (int k = 1; k <= 9; k++) begin
      set_alu(ALU_ADD, 32'(k), 32'h100);
      tick();
    end
    chk("pre_rst_valid", {63'b0, exm_valid}, 64'd1);
    chk("pre_rst_busy", {63'b0, md_busy}, 64'd1);
    #2 rst = 1;
    #1;
    chk("arst_busy", {63'b0, md_busy}, 64'd0);
    chk("arst_exm", {exm_valid, exm_reg_write, exm_mem_write, exm_mem_to_reg, exm_wr_reg,
                     exm_result[15:0], exm_wdata[15:0]}, 64'd0);
    chk("arst_result", exm_result, 32'd0);
    clear_in();
    tick();
    rst = 0;
    read_hilo(gh, gl, stalls);
    chk("arst_stalls", 64'(stalls), 64'd0);
    chk("arst_hi", gh, 32'd0);
    chk("arst_lo", gl, 32'd0);

    // flush coincident with a mult start: nothing starts, HI/LO kept
    md_run(MD_MULTU, 32'hFFFFFFFF, 32'd3, 0, gh, gl);
    chk("multu_hi", gh, 32'd2);
    chk("multu_lo", gl, 32'hFFFFFFFD);
    set_md(MD_MULT, 32'd7, 32'd7);
    flush = 1;
    tick();
    chk("flush_busy", {63'b0, md_busy}, 64'd0);
    chk("flush_valid", {63'b0, exm_valid}, 64'd0);
    read_hilo(gh, gl, stalls);
    chk("flush_stalls", 64'(stalls), 64'd0);
    chk("flush_hi", gh, 32'd2);
    chk("flush_lo", gl, 32'hFFFFFFFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
